// File: rtl/ingress_arb.sv
// Ingress arbiter: four per-port flit FIFOs feeding one memory write port, packet-atomic round robin.
// Latency: a first flit pushed in cycle t into an idle arbiter is presented with write=1 in cycle t+2.
// Backpressure: registered stop_in per port at DEPTH-1 entries; write held stable until wr_ack, gaps wait on write_stop.
module ingress_arb #(
   parameter int NPORTS = 4,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NPORTS-1:0]      pushin_p,
   input  logic [NPORTS-1:0]      firstin_p,
   input  logic [NPORTS-1:0]      lastin_p,
   input  logic [64*NPORTS-1:0]   datain_p,
   output logic [NPORTS-1:0]      stop_in,
   output logic [NPORTS-1:0]      overflow,
   output logic [NPORTS-1:0]      orphan,
   output logic                   write,
   output logic                   pushin,
   output logic                   firstin,
   output logic                   lastin,
   output logic [4:0]             port_in,
   output logic [4:0]             port_out,
   output logic [63:0]            writedata,
   input  logic                   wr_ack,
   input  logic                   write_stop,
   input  logic                   memory_full
);
   localparam int         AW      = $clog2(DEPTH);
   localparam int         CW      = AW + 1;
   localparam int         PW      = $clog2(NPORTS);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] HIGH_C  = CW'(DEPTH - 1);

   typedef struct packed {
      logic        first;
      logic        last;
      logic [63:0] data;
   } flit_t;

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

   flit_t             mem_q [NPORTS][DEPTH];
   logic [AW-1:0]     rp_q  [NPORTS];
   logic [AW-1:0]     wp_q  [NPORTS];
   logic [CW-1:0]     cnt_q [NPORTS];
   flit_t             head  [NPORTS];
   logic [NPORTS-1:0] nonempty, push_ok, pop;
   logic [NPORTS-1:0] stop_q, overflow_q, orphan_q, orphan_d;

   state_t            state_q, state_d;
   logic [PW-1:0]     grant_q, grant_d, rr_q, rr_d;
   logic [PW-1:0]     sel, idx, orph;
   logic              found, orph_found;
   logic              write_q, write_d, pushin_q, pushin_d;
   logic              firstin_q, firstin_d, lastin_q, lastin_d;
   logic [4:0]        port_out_q, port_out_d;
   logic [63:0]       wdata_q, wdata_d;
   logic              mfull_q;

   // Head-of-line view of every FIFO
   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         head[i]     = mem_q[i][rp_q[i]];
         nonempty[i] = (cnt_q[i] != '0);
      end
   end

   // A flit is accepted when there is room or the same FIFO frees a slot this cycle
   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         push_ok[i] = pushin_p[i] & ((cnt_q[i] < DEPTH_C) | pop[i]);
      end
   end

   // Flit storage; validity is tracked by the counts, so no reset is needed
   always_ff @(posedge clk) begin
      for (int i = 0; i < NPORTS; i++) begin
         if (push_ok[i]) begin
            mem_q[i][wp_q[i]] <= {firstin_p[i], lastin_p[i], datain_p[64*i +: 64]};
         end
      end
   end

   // FIFO pointers and counts, upstream stop, sticky drop flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NPORTS; i++) begin
            rp_q[i]  <= '0;
            wp_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         stop_q     <= '0;
         overflow_q <= '0;
      end else begin
         for (int i = 0; i < NPORTS; i++) begin
            if (push_ok[i]) wp_q[i] <= wp_q[i] + 1'b1;
            if (pop[i])     rp_q[i] <= rp_q[i] + 1'b1;
            cnt_q[i]  <= cnt_q[i] + CW'(push_ok[i]) - CW'(pop[i]);
            stop_q[i] <= (cnt_q[i] >= HIGH_C);
            if (pushin_p[i] && !push_ok[i]) overflow_q[i] <= 1'b1;
         end
      end
   end

   // Arbiter state and registered memory-side outputs; the full flag is
   // resampled, so a held-off packet starts two cycles after it clears
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_q       <= '0;
         write_q    <= 1'b0;
         pushin_q   <= 1'b0;
         firstin_q  <= 1'b0;
         lastin_q   <= 1'b0;
         port_out_q <= '0;
         wdata_q    <= '0;
         orphan_q   <= '0;
         mfull_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         write_q    <= write_d;
         pushin_q   <= pushin_d;
         firstin_q  <= firstin_d;
         lastin_q   <= lastin_d;
         port_out_q <= port_out_d;
         wdata_q    <= wdata_d;
         orphan_q   <= orphan_d;
         mfull_q    <= memory_full;
      end
   end

   // Next state: round-robin packet start, headless-flit discard, per-flit handshake
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      write_d    = write_q;
      pushin_d   = pushin_q;
      firstin_d  = firstin_q;
      lastin_d   = lastin_q;
      port_out_d = port_out_q;
      wdata_d    = wdata_q;
      orphan_d   = orphan_q;
      pop        = '0;
      found      = 1'b0;
      sel        = '0;
      idx        = '0;
      orph_found = 1'b0;
      orph       = '0;

      for (int k = 0; k < NPORTS; k++) begin
         idx = rr_q + PW'(k);
         if (!found && nonempty[idx] && head[idx].first) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      for (int i = NPORTS - 1; i >= 0; i--) begin
         if (nonempty[i] && !head[i].first) begin
            orph_found = 1'b1;
            orph       = PW'(i);
         end
      end

      case (state_q)
         IDLE: begin
            if (orph_found) begin
               pop[orph]      = 1'b1;
               orphan_d[orph] = 1'b1;
            end
            if (found && !mfull_q && !write_stop) begin
               grant_d    = sel;
               port_out_d = head[sel].data[4:0];
               write_d    = 1'b1;
               pushin_d   = 1'b1;
               firstin_d  = head[sel].first;
               lastin_d   = head[sel].last;
               wdata_d    = head[sel].data;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (wr_ack) begin
               pop[grant_q] = 1'b1;
               write_d      = 1'b0;
               pushin_d     = 1'b0;
               firstin_d    = 1'b0;
               lastin_d     = 1'b0;
               if (lastin_q) begin
                  rr_d    = grant_q + 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (nonempty[grant_q] && !write_stop) begin
               write_d   = 1'b1;
               pushin_d  = 1'b1;
               firstin_d = head[grant_q].first;
               lastin_d  = head[grant_q].last;
               wdata_d   = head[grant_q].data;
               state_d   = SEND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stop_in   = stop_q;
   assign overflow  = overflow_q;
   assign orphan    = orphan_q;
   assign write     = write_q;
   assign pushin    = pushin_q;
   assign firstin   = firstin_q;
   assign lastin    = lastin_q;
   assign port_in   = 5'(grant_q);
   assign port_out  = port_out_q;
   assign writedata = wdata_q;
endmodule

// File: doc/ingress_arb.md
INGRESS_ARB -- requirements
Module: ingress_arb

Interface
REQ-001 Parameter: NPORTS, 4, number of switch input ports (fixed at 4 in this revision).
REQ-002 Parameter: DEPTH, 4, flits buffered per input port.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 pushin_p  in  4  per-port flit-valid strobe.
REQ-006 firstin_p  in  4  per-port first-flit-of-packet flag, valid with pushin_p.
REQ-007 lastin_p  in  4  per-port last-flit-of-packet flag, valid with pushin_p.
REQ-008 datain_p  in  256  per-port 64-bit flit, packed; port i occupies [64i+63:64i].
REQ-009 stop_in  out  4  per-port backpressure to upstream, registered.
REQ-010 overflow  out  4  per-port sticky flag: a flit was dropped.
REQ-011 orphan  out  4  per-port sticky flag: a head flit without a first flag was discarded.
REQ-012 write  out  1  write request to memory controller.
REQ-013 pushin, firstin, lastin  out  1 each  flit strobes to memory controller, valid with write.
REQ-014 port_in  out  5  index of the granted input port, zero-extended.
REQ-015 port_out  out  5  destination output port of the current packet.
REQ-016 writedata  out  64  flit presented to memory controller.
REQ-017 wr_ack  in  1  one-cycle pulse from memory controller: current flit written.
REQ-018 write_stop  in  1  memory controller refuses new write requests.
REQ-019 memory_full  in  1  no free block; new packets shall not be started.

Function
REQ-020 Each port shall own a DEPTH-entry FIFO of {first, last, data} with a 3-bit occupancy count.
REQ-021 A flit shall be written into FIFO i when pushin_p[i]=1 and either count<DEPTH or the same FIFO pops in that cycle.
REQ-022 Any other flit presented with pushin_p[i]=1 shall be dropped and shall set overflow[i], which holds until reset.
REQ-023 stop_in[i] shall be registered high in the cycle after count reaches DEPTH-1 or more, and low otherwise.
REQ-024 Arbiter states: IDLE, SEND, GAP.
REQ-025 IDLE: when memory_full=0 and write_stop=0, the arbiter shall select the first non-empty port whose head flit has first=1, searching from rr_ptr upward modulo 4.
REQ-026 IDLE: on selection, the arbiter shall latch the grant index and port_out = head data[4:0], then go to SEND.
REQ-027 IDLE: a non-empty port whose head has first=0 shall have that head popped (one per cycle, lowest index first) and orphan[i] set; this shall not block selection of another port in the same cycle.
REQ-028 SEND: write=pushin=1; firstin, lastin and writedata come from the granted head; port_in=grant.
REQ-029 SEND: all SEND outputs shall stay stable until wr_ack, and write shall never be retracted while write_stop is high.
REQ-030 wr_ack in SEND shall pop the granted FIFO.
REQ-031 wr_ack with lastin=1 shall set rr_ptr=(grant+1) mod 4 and go to IDLE; otherwise the arbiter shall go to GAP.
REQ-032 GAP: write=0 for at least one cycle, then SEND when the granted FIFO is non-empty and write_stop=0; otherwise hold in GAP.
REQ-033 Packets are atomic: no other port shall be granted until the granted packet's last flit is acknowledged.
REQ-034 memory_full shall only block packet start in IDLE and shall not affect a packet in progress.
REQ-035 wr_ack outside SEND shall be ignored.
REQ-036 All memory-side outputs shall be registered.
REQ-037 Latency: a first flit pushed at cycle t into an idle arbiter with all other FIFOs empty shall give write=1 at t+2.

Reset
REQ-038 While reset=0 on a clock edge, all FIFOs shall be flushed and counts cleared.
REQ-039 While reset=0 on a clock edge: rr_ptr=0; state=IDLE; write, pushin, firstin, lastin, port_in, port_out, writedata, stop_in, overflow and orphan shall all be 0.
REQ-040 Reset asserted mid-packet shall abandon the packet without issuing a further write; the first cycle after reset deasserts shall be IDLE.

Verification
REQ-041 A 3-flit packet on port 2 with head data[4:0]=5 -> three writes with port_in=2 and port_out=5; firstin on flit 1, lastin on flit 3; write=0 between acks; rr_ptr=3 afterwards.
REQ-042 Single-flit packets on ports 0-3 in the same cycle with rr_ptr=0 -> grants in order 0,1,2,3; with rr_ptr=2 -> grants in order 2,3,0,1.
REQ-043 Port 1 pushes 6 flits with no wr_ack -> stop_in[1]=1 from the cycle after count=3; flits 5-6 dropped; overflow[1]=1; FIFO holds flits 1-4.
REQ-044 write_stop=1 during GAP -> write held at 0 until write_stop=0.
REQ-045 memory_full=1 in IDLE with port 0 pending -> no write; packet starts 2 cycles after memory_full falls.
REQ-046 Orphan flit (first=0) at port 3 head in IDLE -> flit popped, orphan[3]=1, no write; reset=0 mid-packet -> all outputs 0 on the next edge.
